seg7_scan_ctrl: RTL and testbench

//  Time-multiplexes one shared 7-seg BCD decoder across NUM_DIGITS common-cathode digit positions.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_slot_timer.sv | 42 ++++
 rtl/seg7_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
// Holds the scan state encoding and a width helper that never returns zero.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int unsigned BCD_W = 4;
  localparam logic [7:0] SEG_OFF = 8'h00;

  // A one-value counter still needs a 1-bit register.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Loadable down-counter timing one scan phase; tc is high while the count sits at zero,
// which marks the final cycle of the phase that loaded it.
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 1000,
  localparam int unsigned CNT_W = clog2_min1(MAX_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (start) begin
      count_d = target;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scans NUM_DIGITS common-cathode positions through one shared BCD decoder, with a dark gap
// before every digit, frame-aligned value updates and optional leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SHOW_CYCLES  = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  input  logic                        lz_blank,
  output logic [BCD_W-1:0]            digit_out,
  output logic                        decode_en,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic                        frame_done
);

  localparam int unsigned MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = clog2_min1(MAX_CYCLES);
  localparam int unsigned IDX_W      = clog2_min1(NUM_DIGITS);
  localparam int unsigned DATA_W     = BCD_W * NUM_DIGITS;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic [DATA_W-1:0] pending_q, pending_d;
  logic              pending_valid_q, pending_valid_d;

  logic              timer_clear, timer_start, timer_tc;
  logic [CNT_W-1:0]  timer_target, timer_count;

  logic              frame_update, idle_exit, upper_zero, lz_suppress, last_show_cycle;
  logic [BCD_W-1:0]  digit_out_d;
  logic              decode_en_d, frame_done_d;
  logic [NUM_DIGITS-1:0] digit_sel_d;

  seg7_slot_timer #(
    .MAX_COUNT (MAX_CYCLES)
  ) u_slot_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .start  (timer_start),
    .target (timer_target),
    .count  (timer_count),
    .tc     (timer_tc)
  );

  // Sequencing: every state change restarts the slot timer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_clear  = 1'b0;
    timer_start  = 1'b0;
    timer_target = BLANK_LAST;
    frame_update = 1'b0;
    idle_exit    = 1'b0;
    if (!enable) begin
      state_d     = IDLE;
      idx_d       = '0;
      timer_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = BLANK;
          idx_d       = '0;
          timer_start = 1'b1;
          idle_exit   = 1'b1;
        end
        BLANK: begin
          if (timer_tc) begin
            state_d      = SHOW;
            timer_start  = 1'b1;
            timer_target = SHOW_LAST;
          end
        end
        SHOW: begin
          if (timer_tc) begin
            state_d     = BLANK;
            timer_start = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d        = '0;
              frame_update = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d     = IDLE;
          idx_d       = '0;
          timer_clear = 1'b1;
        end
      endcase
    end
  end

  // A same-cycle load wins at an update point, so pending_d is always the value to show.
  always_comb begin
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    active_d        = active_q;
    if (load) begin
      pending_d       = bcd_in;
      pending_valid_d = 1'b1;
    end
    if (idle_exit) begin
      active_d        = pending_d;
      pending_valid_d = 1'b0;
    end else if (frame_update) begin
      if (load || pending_valid_q) begin
        active_d = pending_d;
      end
      pending_valid_d = 1'b0;
    end
  end

  // Outputs are computed from next-state values so the registered copies line up with state.
  always_comb begin
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx_d) && active_q[k*BCD_W +: BCD_W] != '0) begin
        upper_zero = 1'b0;
      end
    end
    lz_suppress     = lz_blank && (idx_d != '0) && upper_zero;
    last_show_cycle = (idx_d == LAST_IDX) &&
                      (timer_start ? (SHOW_LAST == '0) : (timer_count == CNT_W'(1)));

    digit_sel_d  = '0;
    digit_out_d  = '0;
    decode_en_d  = 1'b0;
    frame_done_d = 1'b0;
    if (state_d == SHOW) begin
      digit_sel_d  = NUM_DIGITS'(1) << idx_d;
      digit_out_d  = active_q[idx_d*BCD_W +: BCD_W];
      decode_en_d  = !lz_suppress;
      frame_done_d = last_show_cycle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      digit_out       <= '0;
      decode_en       <= 1'b0;
      digit_sel       <= '0;
      frame_done      <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      digit_out       <= digit_out_d;
      decode_en       <= decode_en_d;
      digit_sel       <= digit_sel_d;
      frame_done      <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: each observed digit slot is packed into one word and
// compared with the next word queued when the matching stimulus was planned.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, enable, load, lz_blank;
  logic [15:0] bcd_in;
  logic [3:0]  digit_out;
  logic        decode_en;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // {sel, digit, decode_en, frame_done pattern, show length, blank length, unstable}
  typedef logic [27:0] slot_w_t;
  slot_w_t exp_q[$];

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .SHOW_CYCLES  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .bcd_in     (bcd_in),
    .lz_blank   (lz_blank),
    .digit_out  (digit_out),
    .decode_en  (decode_en),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  function automatic slot_w_t pack_slot(input logic [3:0] sel, input logic [3:0] dig,
                                        input logic en, input logic [1:0] fd,
                                        input logic [7:0] len, input logic [7:0] blank,
                                        input logic unstable);
    return {sel, dig, en, fd, len, blank, unstable};
  endfunction

  // Expected four slots of one frame showing val.
  function automatic void push_frame(input logic [15:0] val, input logic lz);
    logic [3:0]  nib;
    logic [15:0] upper;
    logic        en;
    for (int k = 0; k < 4; k++) begin
      nib   = val[4*k +: 4];
      upper = val >> (4 * k);
      en    = !(lz && k > 0 && upper == 16'h0);
      exp_q.push_back(pack_slot(4'(1 << k), nib, en, (k == 3) ? 2'd1 : 2'd0, 8'd8, 8'd2, 1'b0));
    end
  endfunction

  // Called at a negedge; returns at the first dark negedge after the slot. Optionally pulses
  // load at show offset load_at.
  task automatic wait_slot(input int load_at, input logic [15:0] load_val,
                           output slot_w_t obs, output int fd_cyc);
    int blank, len, fd_cnt, fd_at;
    logic [3:0] sel, dig;
    logic en, unstable;
    logic [1:0] fd;
    blank = 0; len = 0; fd_cnt = 0; fd_at = -1; unstable = 1'b0; fd_cyc = -1;
    while (digit_sel == 4'h0 && blank < 100) begin
      if (frame_done !== 1'b0 || decode_en !== 1'b0) unstable = 1'b1;
      blank++;
      @(negedge clk);
      load = 1'b0;
    end
    sel = digit_sel; dig = digit_out; en = decode_en;
    while (sel != 4'h0 && digit_sel == sel && len < 100) begin
      if (digit_out !== dig || decode_en !== en) unstable = 1'b1;
      if (frame_done) begin
        fd_cnt++; fd_at = len; fd_cyc = cyc;
      end
      if (len == load_at) begin
        load = 1'b1; bcd_in = load_val;
      end
      len++;
      @(negedge clk);
      load = 1'b0;
    end
    fd = (fd_cnt == 0) ? 2'd0 : ((fd_cnt == 1 && fd_at == len - 1) ? 2'd1 : 2'd3);
    obs = pack_slot(sel, dig, en, fd, 8'(len), 8'(blank), unstable);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; load = 1'b0; lz_blank = 1'b0; bcd_in = 16'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (digit_sel !== 4'h0) begin n_fail++; $display("FAIL reset_sel: got %b required 0000", digit_sel); end
    n_cmp++; if (digit_out !== 4'h0) begin n_fail++; $display("FAIL reset_digit: got %h required 0", digit_out); end
    n_cmp++; if (decode_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b required 0", decode_en); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b required 0", frame_done); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({digit_sel, digit_out, decode_en, frame_done} !== 10'h0) begin
      n_fail++;
      $display("FAIL idle_dark: got %h required 000", {digit_sel, digit_out, decode_en, frame_done});
    end
  endtask

  task automatic test_basic();
    slot_w_t obs, want;
    int fdc, fd_first;
    fd_first = -1000;
    enable = 1'b1; load = 1'b1; bcd_in = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    push_frame(16'h1234, 1'b0);
    push_frame(16'h1234, 1'b0);
    for (int s = 0; s < 8; s++) begin
      wait_slot(-1, 16'h0, obs, fdc);
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_cmp++;
      if (obs !== want) begin n_fail++; $display("FAIL basic slot %0d: got %h required %h", s, obs, want); end
      if (s == 3) fd_first = fdc;
      if (s == 7) begin
        n_cmp++;
        if (fdc - fd_first != 40) begin
          n_fail++; $display("FAIL frame_period: got %0d required 40", fdc - fd_first);
        end
      end
    end
  endtask

  task automatic test_lz();
    slot_w_t obs, want;
    int fdc;
    lz_blank = 1'b1;
    push_frame(16'h1234, 1'b1);
    push_frame(16'h0070, 1'b1);
    push_frame(16'h0070, 1'b1);
    push_frame(16'h0000, 1'b1);
    for (int s = 0; s < 16; s++) begin
      wait_slot((s % 8 == 0) ? 0 : -1, (s < 8) ? 16'h0070 : 16'h0000, obs, fdc);
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_cmp++;
      if (obs !== want) begin n_fail++; $display("FAIL lz slot %0d: got %h required %h", s, obs, want); end
    end
  endtask

  task automatic test_midframe();
    slot_w_t obs, want;
    int fdc, la;
    logic [15:0] lv;
    lz_blank = 1'b0;
    push_frame(16'h0000, 1'b0);
    push_frame(16'h1234, 1'b0);
    push_frame(16'h5678, 1'b0);
    for (int s = 0; s < 12; s++) begin
      la = (s == 0) ? 0 : ((s == 5) ? 3 : -1);
      lv = (s == 0) ? 16'h1234 : 16'h5678;
      wait_slot(la, lv, obs, fdc);
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_cmp++;
      if (obs !== want) begin n_fail++; $display("FAIL midframe slot %0d: got %h required %h", s, obs, want); end
    end
  endtask

  task automatic test_back_to_back();
    slot_w_t obs, want;
    int fdc;
    push_frame(16'h5678, 1'b0);
    push_frame(16'h9999, 1'b0);
    for (int s = 0; s < 8; s++) begin
      wait_slot((s == 3) ? 7 : -1, 16'h9999, obs, fdc);
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_cmp++;
      if (obs !== want) begin n_fail++; $display("FAIL same_cycle slot %0d: got %h required %h", s, obs, want); end
    end
  endtask

  task automatic test_enable();
    slot_w_t obs, want;
    int fdc, g;
    push_frame(16'h9999, 1'b0);
    for (int s = 0; s < 2; s++) begin
      wait_slot((s == 0) ? 3 : -1, 16'h3B21, obs, fdc);
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_cmp++;
      if (obs !== want) begin n_fail++; $display("FAIL enable_pre slot %0d: got %h required %h", s, obs, want); end
    end
    exp_q.delete();
    g = 0;
    while (digit_sel !== 4'b0100 && g < 50) begin g++; @(negedge clk); end
    n_cmp++;
    if (digit_sel !== 4'b0100) begin n_fail++; $display("FAIL enable_reach_idx2: got %b required 0100", digit_sel); end
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (digit_sel !== 4'h0) begin n_fail++; $display("FAIL disable_sel: got %b required 0000", digit_sel); end
    n_cmp++; if (digit_out !== 4'h0) begin n_fail++; $display("FAIL disable_digit: got %h required 0", digit_out); end
    n_cmp++; if (decode_en !== 1'b0) begin n_fail++; $display("FAIL disable_en: got %b required 0", decode_en); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL disable_fd: got %b required 0", frame_done); end
    repeat (4) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    push_frame(16'h3B21, 1'b0);
    for (int s = 0; s < 4; s++) begin
      wait_slot(-1, 16'h0, obs, fdc);
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_cmp++;
      if (obs !== want) begin n_fail++; $display("FAIL reenable slot %0d: got %h required %h", s, obs, want); end
    end
  endtask

  task automatic test_reset_mid();
    slot_w_t obs, want;
    int fdc, g;
    push_frame(16'h3B21, 1'b0);
    wait_slot(-1, 16'h0, obs, fdc);
    want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("FAIL prereset slot: got %h required %h", obs, want); end
    exp_q.delete();
    g = 0;
    while (digit_sel === 4'h0 && g < 50) begin g++; @(negedge clk); end
    @(negedge clk);
    rst = 1'b1; load = 1'b1; bcd_in = 16'hFFFF;
    @(negedge clk);
    load = 1'b0;
    n_cmp++; if (digit_sel !== 4'h0) begin n_fail++; $display("FAIL midrst_sel: got %b required 0000", digit_sel); end
    n_cmp++; if (digit_out !== 4'h0) begin n_fail++; $display("FAIL midrst_digit: got %h required 0", digit_out); end
    n_cmp++; if (decode_en !== 1'b0) begin n_fail++; $display("FAIL midrst_en: got %b required 0", decode_en); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_fd: got %b required 0", frame_done); end
    rst = 1'b0;
    @(negedge clk);
    push_frame(16'h0000, 1'b0);
    for (int s = 0; s < 4; s++) begin
      wait_slot(-1, 16'h0, obs, fdc);
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_cmp++;
      if (obs !== want) begin n_fail++; $display("FAIL postrst slot %0d: got %h required %h", s, obs, want); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_midframe();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
